// File: rtl/uart_tx_if.sv
// Connection bundle between the UART register block (master) and the transmit engine (slave).
interface uart_tx_if;
  logic        txd_wr;
  logic [8:0]  txd_reg_txd;
  logic        tc_clr;
  logic [11:0] br_reg_mentissa;
  logic [3:0]  br_reg_fraction;
  logic        cr0_reg_te;
  logic        cr0_reg_wdlen;
  logic        cr0_reg_pce;
  logic        cr0_reg_ps;
  logic [1:0]  cr0_reg_stoplen;
  logic        cr1_reg_dmate;
  logic        uart_tx;
  logic        sr_reg_txe;
  logic        sr_reg_tc;
  logic        tx_busy;
  logic        tx_dma_req;

  modport master (
    output txd_wr, txd_reg_txd, tc_clr, br_reg_mentissa, br_reg_fraction,
           cr0_reg_te, cr0_reg_wdlen, cr0_reg_pce, cr0_reg_ps, cr0_reg_stoplen,
           cr1_reg_dmate,
    input  uart_tx, sr_reg_txe, sr_reg_tc, tx_busy, tx_dma_req
  );

  modport slave (
    input  txd_wr, txd_reg_txd, tc_clr, br_reg_mentissa, br_reg_fraction,
           cr0_reg_te, cr0_reg_wdlen, cr0_reg_pce, cr0_reg_ps, cr0_reg_stoplen,
           cr1_reg_dmate,
    output uart_tx, sr_reg_txe, sr_reg_tc, tx_busy, tx_dma_req
  );
endinterface

// File: rtl/uart_tx_core.sv
// UART transmit engine: holding + shift register, programmable bit period,
// 8/9 data bits, optional parity and 1/1.5/2 stop bits; all outputs registered.
module uart_tx_core #(
  parameter int unsigned BAUD_MIN = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);

  localparam logic [15:0] BAUD_MIN_P = 16'(BAUD_MIN);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  function automatic logic parity_fn(input logic [8:0] data, input logic wdlen, input logic ps);
    logic [8:0] m;
    m = wdlen ? data : {1'b0, data[7:0]};
    return (^m) ^ ps;
  endfunction

  function automatic logic [16:0] stop_cycles_fn(input logic [15:0] p, input logic [1:0] stoplen);
    logic [16:0] r;
    case (stoplen)
      2'b10:   r = {p, 1'b0};
      2'b11:   r = {1'b0, p} + {2'b00, p[15:1]};
      default: r = {1'b0, p};
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  hold_q, hold_d;
  logic [8:0]  shift_q, shift_d;
  logic [15:0] p_q, p_d;
  logic        wdlen_q, wdlen_d;
  logic        pce_q, pce_d;
  logic        ps_q, ps_d;
  logic [1:0]  stop_q, stop_d;
  logic        tx_q, tx_d;
  logic        txe_q, txe_d;
  logic        tc_q, tc_d;
  logic        busy_q, busy_d;
  logic        dma_q, dma_d;

  logic [15:0] p_prog_s;
  logic [15:0] p_clamp_s;
  logic [16:0] term_s;
  logic        tick_s;
  logic        last_bit_s;
  logic [3:0]  next_bit_s;
  logic        start_s;
  logic        done_s;

  // Next-state computation for the frame sequencer, buffers and status flags.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    hold_d   = hold_q;
    shift_d  = shift_q;
    p_d      = p_q;
    wdlen_d  = wdlen_q;
    pce_d    = pce_q;
    ps_d     = ps_q;
    stop_d   = stop_q;
    tx_d     = tx_q;
    txe_d    = txe_q;
    tc_d     = tc_q;
    start_s  = 1'b0;
    done_s   = 1'b0;

    p_prog_s   = {bus.br_reg_mentissa, bus.br_reg_fraction};
    p_clamp_s  = (p_prog_s < BAUD_MIN_P) ? BAUD_MIN_P : p_prog_s;
    term_s     = (state_q == ST_STOP) ? (stop_cycles_fn(p_q, stop_q) - 17'd1)
                                      : ({1'b0, p_q} - 17'd1);
    tick_s     = (cnt_q == term_s);
    last_bit_s = wdlen_q ? (bit_q == 4'd8) : (bit_q == 4'd7);
    next_bit_s = bit_q + 4'd1;

    case (state_q)
      ST_IDLE: begin
        if (!txe_q && bus.cr0_reg_te) begin
          start_s = 1'b1;
        end else begin
          tx_d = 1'b1;
        end
      end
      ST_START: begin
        if (tick_s) begin
          cnt_d   = 17'd0;
          bit_d   = 4'd0;
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          cnt_d = 17'd0;
          if (!last_bit_s) begin
            bit_d = next_bit_s;
            tx_d  = shift_q[next_bit_s];
          end else if (pce_q) begin
            tx_d    = parity_fn(shift_q, wdlen_q, ps_q);
            state_d = ST_PARITY;
          end else begin
            tx_d    = 1'b1;
            state_d = ST_STOP;
          end
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      ST_PARITY: begin
        if (tick_s) begin
          cnt_d   = 17'd0;
          tx_d    = 1'b1;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q + 17'd1;
        end
      end
      ST_STOP: begin
        if (!tick_s) begin
          cnt_d = cnt_q + 17'd1;
        end else if (!txe_q && bus.cr0_reg_te) begin
          start_s = 1'b1;
        end else begin
          cnt_d   = 17'd0;
          tx_d    = 1'b1;
          done_s  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        cnt_d   = 17'd0;
        tx_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase

    // Frame start snapshots the configuration so mid-frame register writes wait a frame.
    if (start_s) begin
      shift_d = hold_q;
      p_d     = p_clamp_s;
      wdlen_d = bus.cr0_reg_wdlen;
      pce_d   = bus.cr0_reg_pce;
      ps_d    = bus.cr0_reg_ps;
      stop_d  = bus.cr0_reg_stoplen;
      cnt_d   = 17'd0;
      bit_d   = 4'd0;
      tx_d    = 1'b0;
      state_d = ST_START;
    end else begin
      shift_d = shift_q;
    end

    if (bus.txd_wr) begin
      hold_d = bus.txd_reg_txd;
      txe_d  = 1'b0;
    end else if (start_s) begin
      txe_d = 1'b1;
    end else begin
      txe_d = txe_q;
    end

    if (bus.txd_wr) begin
      tc_d = 1'b0;
    end else if (bus.tc_clr) begin
      tc_d = 1'b0;
    end else if (done_s) begin
      tc_d = 1'b1;
    end else begin
      tc_d = tc_q;
    end

    busy_d = (state_d != ST_IDLE);
    dma_d  = bus.cr1_reg_dmate & txe_d;
  end

  // State register for the whole engine, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 17'd0;
      bit_q   <= 4'd0;
      hold_q  <= 9'd0;
      shift_q <= 9'd0;
      p_q     <= BAUD_MIN_P;
      wdlen_q <= 1'b0;
      pce_q   <= 1'b0;
      ps_q    <= 1'b0;
      stop_q  <= 2'b00;
      tx_q    <= 1'b1;
      txe_q   <= 1'b1;
      tc_q    <= 1'b1;
      busy_q  <= 1'b0;
      dma_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      p_q     <= p_d;
      wdlen_q <= wdlen_d;
      pce_q   <= pce_d;
      ps_q    <= ps_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      txe_q   <= txe_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      dma_q   <= dma_d;
    end
  end

  assign bus.uart_tx    = tx_q;
  assign bus.sr_reg_txe = txe_q;
  assign bus.sr_reg_tc  = tc_q;
  assign bus.tx_busy    = busy_q;
  assign bus.tx_dma_req = dma_q;

endmodule
